sched_ctrl: RTL and testbench
=============================

// Module: sched_ctrl
// PURPOSE
// - Pipeline scheduler: consumes the scheduling requests the ID stage issues and
//   drives the stall/bubble controls of the 5-stage pipe (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
// - Closes the load-use loop: after a LW pause, asserts read_from_last2 so ID
//   re-decodes with the MEM/WB forwarded value.
// - Also arbitrates MEM's structural bus pause and interrupt flush.
// PARAMETERS
// - CNT_W           4  width of the pause counter (must equal idi sched_count width)
// - LW_PAUSE_CYCLES 1  stall cycles inserted for SCHED_PAUSE_FOR_LW (1..2^CNT_W-1)
// PORTS
// - clk                    in   1      pipeline clock
// - rst                    in   1      asynchronous, active-high reset
// - schi_pause_request     in   1      ID requests a stall this cycle
// - schi_sched_type        in   4      ID request type (`SCHED_*)
// - schi_sched_count       in   CNT_W  cycle count for `SCHED_PAUSE_N
// - schi_mem_pause         in   1      MEM owns shared RAM bus this cycle (LW/SW)
// - schi_interrupt         in   1      ID/EX interrupt: flush younger stages
// - scho_stall             out  5      [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB hold
// - scho_bubble_if_id      out  1      load NOP into IF/ID
// - scho_bubble_id_ex      out  1      load NOP into ID/EX
// - scho_read_from_last2   out  2      to ID idi_read_from_last2; 2'b01 = use last2 result
// - scho_busy              out  1      state != S_RUN
// BEHAVIOUR
// - States: S_RUN, S_LW_WAIT, S_COUNT, S_LW_REPLAY. Registered: state, cnt[CNT_W-1:0].
//   Outputs are combinational from state and inputs.
// - Reset (async, rst=1): state=S_RUN, cnt=0.
//   All outputs 0 while in reset and in idle S_RUN with no inputs asserted.
// - Priority, highest first: interrupt > ID request > mem pause.
// - S_RUN:
//   - interrupt: bubble_if_id=1, bubble_id_ex=1, stall=0; ID request dropped; stay S_RUN.
//   - pause_request & type==`SCHED_PAUSE_FOR_LW:
//     - stall=5'b00011, bubble_id_ex=1.
//     - If LW_PAUSE_CYCLES==1 -> S_LW_REPLAY; else cnt=LW_PAUSE_CYCLES-1 -> S_LW_WAIT.
//   - pause_request & type==`SCHED_PAUSE_N & count!=0:
//     - stall=5'b00011, bubble_id_ex=1.
//     - count==1 -> S_RUN; else cnt=count-1 -> S_COUNT.
//   - pause_request with count==0, or type==`SCHED_CONTINUE: treated as no request.
//   - Unknown type: treated as no request.
//   - mem_pause (no higher event): stall=5'b00001, bubble_if_id=1 (IF lost the bus,
//     PC holds, ID gets NOP). Later stages advance.
// - S_LW_WAIT / S_COUNT:
//   - stall=5'b00011, bubble_id_ex=1; cnt decrements each cycle.
//   - On the cycle cnt==1: S_LW_WAIT -> S_LW_REPLAY, S_COUNT -> S_RUN.
//   - ID requests ignored.
//   - mem_pause additionally asserts nothing (PC already held).
// - S_LW_REPLAY (exactly 1 cycle):
//   - read_from_last2=2'b01, stall=0; ID's re-decode uses last2 result.
//   - Any pause_request this cycle is ignored (replayed instr).
//   - Next state: S_RUN.
// - Interrupt in any non-RUN state: abort to S_RUN next edge, cnt=0.
//   Same cycle: bubble_if_id=1, bubble_id_ex=1, stall=0, read_from_last2=0.
// - Total stall for PAUSE_N = count cycles exactly; for LW = LW_PAUSE_CYCLES cycles + 1 replay.
// - Counter arithmetic modulo 2^CNT_W; cnt never decrements below 1 in a wait state.
// - Reset mid-pause: immediate return to S_RUN, outputs 0 next delta.
// STRUCTURE
// - defines.v gains:
//   - `SCHED_PAUSE_N (4'h2).
//   - `STALL_PC .. `STALL_MEM_WB bit indices.
//   - `SCHED_S_RUN/LW_WAIT/COUNT/LW_REPLAY 2-bit state encodings.
// - Existing `SCHED_CONTINUE/`SCHED_PAUSE_FOR_LW reused.
// - No sub-module; single always @(posedge clk or posedge rst) for state/cnt
//   plus one combinational output block.
// TESTING
// - LW hazard: req type=PAUSE_FOR_LW 1 cycle ->
//   stall=00011, bubble_id_ex=1 for 1 cycle, then read_from_last2=01 for 1 cycle, then idle.
// - PAUSE_N count=3 -> stall=00011 for exactly 3 cycles, busy=1 for cycles 2-3, then 0.
//   count=0 -> no stall.
// - mem_pause held 2 cycles in S_RUN -> stall=00001, bubble_if_id=1 both cycles.
//   Concurrent PAUSE_N count=2 -> stall=00011 wins.
// - Interrupt in 2nd cycle of PAUSE_N count=4 -> bubble_if_id=bubble_id_ex=1,
//   stall=0 that cycle, S_RUN next.
// - rst pulsed asynchronously (mid-clock) during S_COUNT cnt=5 ->
//   all outputs 0 immediately; after release, PAUSE_N count=1 -> single stall cycle.
// - Back-to-back: PAUSE_FOR_LW request repeated during S_LW_REPLAY ->
//   ignored; no second pause.

Source files
------------

// File: rtl/sched_ctrl_pkg.sv
// Shared scheduling constants for the pipeline scheduler: ID request type
// codes, stall-vector bit indices, FSM state encoding and request decoding.
package sched_ctrl_pkg;

    // Request types issued by the ID stage
    localparam logic [3:0] SCHED_CONTINUE     = 4'h0;
    localparam logic [3:0] SCHED_PAUSE_FOR_LW = 4'h1;
    localparam logic [3:0] SCHED_PAUSE_N      = 4'h2;

    // Bit positions inside the 5-bit stall vector
    localparam int STALL_PC     = 0;
    localparam int STALL_IF_ID  = 1;
    localparam int STALL_ID_EX  = 2;
    localparam int STALL_EX_MEM = 3;
    localparam int STALL_MEM_WB = 4;
    localparam int STALL_W      = 5;

    // read_from_last2 encodings driven back to ID
    localparam logic [1:0] RFL2_NONE  = 2'b00;
    localparam logic [1:0] RFL2_LAST2 = 2'b01;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        S_RUN       = 2'd0,
        S_LW_WAIT   = 2'd1,
        S_COUNT     = 2'd2,
        S_LW_REPLAY = 2'd3
    } sched_state_e;

    // Decoded form of an ID request; malformed requests collapse to REQ_NONE
    typedef enum logic [1:0] {
        REQ_NONE    = 2'd0,
        REQ_LW      = 2'd1,
        REQ_PAUSE_N = 2'd2
    } sched_req_e;

    // A PAUSE_N with a zero count and any unknown type mean "no request"
    function automatic sched_req_e decode_req(input logic       pause_request,
                                              input logic [3:0] sched_type,
                                              input logic       count_nonzero);
        sched_req_e req;
        req = REQ_NONE;
        if (pause_request) begin
            case (sched_type)
                SCHED_CONTINUE:     req = REQ_NONE;
                SCHED_PAUSE_FOR_LW: req = REQ_LW;
                SCHED_PAUSE_N:      req = count_nonzero ? REQ_PAUSE_N : REQ_NONE;
                default:            req = REQ_NONE;
            endcase
        end
        return req;
    endfunction

endpackage

// File: rtl/sched_ctrl.sv
// Pipeline scheduler: turns ID stall requests, MEM bus pauses and interrupts
// into stall/bubble controls for the 5-stage pipe, and closes the load-use
// loop by requesting a one-cycle re-decode with the MEM/WB forwarded value.
module sched_ctrl
    import sched_ctrl_pkg::*;
#(
    parameter int CNT_W           = 4,
    parameter int LW_PAUSE_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                schi_pause_request,
    input  logic [3:0]          schi_sched_type,
    input  logic [CNT_W-1:0]    schi_sched_count,
    input  logic                schi_mem_pause,
    input  logic                schi_interrupt,
    output logic [STALL_W-1:0]  scho_stall,
    output logic                scho_bubble_if_id,
    output logic                scho_bubble_id_ex,
    output logic [1:0]          scho_read_from_last2,
    output logic                scho_busy
);

    // Remaining wait cycles after the first (RUN-state) stall cycle of an LW pause
    localparam logic [CNT_W-1:0] LW_RELOAD = CNT_W'(LW_PAUSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    sched_state_e     state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    sched_req_e       req;
    logic             hold_pc, hold_if_id;

    assign req       = decode_req(schi_pause_request, schi_sched_type,
                                  (schi_sched_count != '0));
    assign scho_busy = (state != S_RUN);

    // State and pause counter register; reset drops any pause in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and output decode; interrupt outranks ID requests, which outrank MEM pause
    always_comb begin
        state_nxt            = state;
        cnt_nxt              = cnt;
        hold_pc              = 1'b0;
        hold_if_id           = 1'b0;
        scho_bubble_if_id    = 1'b0;
        scho_bubble_id_ex    = 1'b0;
        scho_read_from_last2 = RFL2_NONE;

        if (schi_interrupt) begin
            // Flush the younger stages and abandon any pause or replay in progress
            scho_bubble_if_id = 1'b1;
            scho_bubble_id_ex = 1'b1;
            state_nxt         = S_RUN;
            cnt_nxt           = '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (req == REQ_LW) begin
                        hold_pc           = 1'b1;
                        hold_if_id        = 1'b1;
                        scho_bubble_id_ex = 1'b1;
                        if (LW_PAUSE_CYCLES == 1) begin
                            state_nxt = S_LW_REPLAY;
                        end else begin
                            cnt_nxt   = LW_RELOAD;
                            state_nxt = S_LW_WAIT;
                        end
                    end else if (req == REQ_PAUSE_N) begin
                        hold_pc           = 1'b1;
                        hold_if_id        = 1'b1;
                        scho_bubble_id_ex = 1'b1;
                        if (schi_sched_count != CNT_ONE) begin
                            cnt_nxt   = schi_sched_count - CNT_ONE;
                            state_nxt = S_COUNT;
                        end
                    end else if (schi_mem_pause) begin
                        // IF lost the shared bus: hold PC and hand ID a NOP
                        hold_pc           = 1'b1;
                        scho_bubble_if_id = 1'b1;
                    end
                end
                S_LW_WAIT, S_COUNT: begin
                    // Front of the pipe frozen; MEM pause needs nothing extra
                    hold_pc           = 1'b1;
                    hold_if_id        = 1'b1;
                    scho_bubble_id_ex = 1'b1;
                    if (cnt == CNT_ONE) begin
                        cnt_nxt   = '0;
                        state_nxt = (state == S_LW_WAIT) ? S_LW_REPLAY : S_RUN;
                    end else begin
                        cnt_nxt = cnt - CNT_ONE;
                    end
                end
                S_LW_REPLAY: begin
                    // ID re-decodes the stalled instruction; its request is stale
                    scho_read_from_last2 = RFL2_LAST2;
                    state_nxt            = S_RUN;
                end
                default: begin
                    state_nxt = S_RUN;
                    cnt_nxt   = '0;
                end
            endcase
        end

        // Only the PC and IF/ID registers are ever held; later stages always advance
        scho_stall               = '0;
        scho_stall[STALL_PC]     = hold_pc;
        scho_stall[STALL_IF_ID]  = hold_if_id;
        scho_stall[STALL_ID_EX]  = 1'b0;
        scho_stall[STALL_EX_MEM] = 1'b0;
        scho_stall[STALL_MEM_WB] = 1'b0;
    end

endmodule

// File: tb/tb_sched_ctrl.sv
// Testbench for sched_ctrl: directed vector table, asynchronous reset
// sequence, and randomized traffic against a queue-based reference model.
module tb_sched_ctrl;

    localparam int CNT_W = 4;
    localparam int LWC   = 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             schi_pause_request;
    logic [3:0]       schi_sched_type;
    logic [CNT_W-1:0] schi_sched_count;
    logic             schi_mem_pause;
    logic             schi_interrupt;
    logic [4:0]       scho_stall;
    logic             scho_bubble_if_id;
    logic             scho_bubble_id_ex;
    logic [1:0]       scho_read_from_last2;
    logic             scho_busy;

    sched_ctrl #(.CNT_W(CNT_W), .LW_PAUSE_CYCLES(LWC)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .schi_pause_request   (schi_pause_request),
        .schi_sched_type      (schi_sched_type),
        .schi_sched_count     (schi_sched_count),
        .schi_mem_pause       (schi_mem_pause),
        .schi_interrupt       (schi_interrupt),
        .scho_stall           (scho_stall),
        .scho_bubble_if_id    (scho_bubble_if_id),
        .scho_bubble_id_ex    (scho_bubble_id_ex),
        .scho_read_from_last2 (scho_read_from_last2),
        .scho_busy            (scho_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Output word layout: {stall[4:0], bubble_if_id, bubble_id_ex, read_from_last2[1:0], busy}
    function automatic logic [9:0] outs();
        return {scho_stall, scho_bubble_if_id, scho_bubble_id_ex, scho_read_from_last2, scho_busy};
    endfunction

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got stall=%b bif=%b bie=%b rfl2=%b busy=%b, expected stall=%b bif=%b bie=%b rfl2=%b busy=%b",
                     name, got[9:5], got[4], got[3], got[2:1], got[0],
                     exp[9:5], exp[4], exp[3], exp[2:1], exp[0]);
        end
    endtask

    // Reference model: a queue of the per-cycle outputs still owed by an accepted pause.
    // Non-empty queue means the scheduler is busy and ignores new ID requests.
    localparam logic [8:0] ENT_STALL  = {5'b00011, 1'b0, 1'b1, 2'b00};
    localparam logic [8:0] ENT_REPLAY = {5'b00000, 1'b0, 1'b0, 2'b01};
    localparam logic [8:0] ENT_INTR   = {5'b00000, 1'b1, 1'b1, 2'b00};
    localparam logic [8:0] ENT_MEM    = {5'b00001, 1'b1, 1'b0, 2'b00};
    logic [8:0] mq[$];

    task automatic model(input logic pr, input logic [3:0] typ, input logic [CNT_W-1:0] c,
                         input logic mp, input logic it, output logic [9:0] exp);
        logic [8:0] o;
        logic       busy;
        o    = '0;
        busy = (mq.size() != 0);
        if (it) begin
            o = ENT_INTR;
            mq.delete();
        end else if (busy) begin
            o = mq.pop_front();
        end else if (pr && typ == 4'h1) begin
            o = ENT_STALL;
            for (int i = 1; i < LWC; i++) mq.push_back(ENT_STALL);
            mq.push_back(ENT_REPLAY);
        end else if (pr && typ == 4'h2 && c != 0) begin
            o = ENT_STALL;
            for (int i = 1; i < int'(c); i++) mq.push_back(ENT_STALL);
        end else if (mp) begin
            o = ENT_MEM;
        end
        exp = {o, busy};
    endtask

    // One pipeline cycle: drive at posedge+1, sample on the falling edge, advance
    task automatic cycle(input logic pr, input logic [3:0] typ, input logic [CNT_W-1:0] c,
                         input logic mp, input logic it,
                         output logic [9:0] got, output logic [9:0] mexp);
        schi_pause_request = pr;
        schi_sched_type    = typ;
        schi_sched_count   = c;
        schi_mem_pause     = mp;
        schi_interrupt     = it;
        model(pr, typ, c, mp, it, mexp);
        #4;
        got = outs();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic             pr;
        logic [3:0]       typ;
        logic [CNT_W-1:0] c;
        logic             mp;
        logic             it;
        logic [9:0]       exp;
        string            name;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic pr, input logic [3:0] typ, input logic [CNT_W-1:0] c,
                                input logic mp, input logic it, input logic [9:0] exp,
                                input string name);
        vec_t v;
        v.pr = pr; v.typ = typ; v.c = c; v.mp = mp; v.it = it; v.exp = exp; v.name = name;
        return v;
    endfunction

    initial begin
        logic [9:0] got, mexp;
        int r;
        logic [3:0] typ;
        logic [CNT_W-1:0] c;

        // Directed vectors, one row per cycle, expectations taken from the behaviour rules
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 10'b00000_0_0_00_0, "idle"));
        tbl.push_back(mk(1, 4'h1, 0, 0, 0, 10'b00011_0_1_00_0, "lw_stall"));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 10'b00000_0_0_01_1, "lw_replay"));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 10'b00000_0_0_00_0, "lw_done"));
        tbl.push_back(mk(1, 4'h2, 3, 0, 0, 10'b00011_0_1_00_0, "pn3_c1"));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 10'b00011_0_1_00_1, "pn3_c2"));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 10'b00011_0_1_00_1, "pn3_c3"));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 10'b00000_0_0_00_0, "pn3_done"));
        tbl.push_back(mk(1, 4'h2, 0, 0, 0, 10'b00000_0_0_00_0, "pn0_nostall"));
        tbl.push_back(mk(0, 4'h0, 0, 1, 0, 10'b00001_1_0_00_0, "mem_c1"));
        tbl.push_back(mk(0, 4'h0, 0, 1, 0, 10'b00001_1_0_00_0, "mem_c2"));
        tbl.push_back(mk(1, 4'h2, 2, 1, 0, 10'b00011_0_1_00_0, "pn2_over_mem_c1"));
        tbl.push_back(mk(0, 4'h0, 0, 1, 0, 10'b00011_0_1_00_1, "pn2_over_mem_c2"));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 10'b00000_0_0_00_0, "pn2_done"));
        tbl.push_back(mk(1, 4'h2, 4, 0, 0, 10'b00011_0_1_00_0, "pn4_c1"));
        tbl.push_back(mk(0, 4'h0, 0, 0, 1, 10'b00000_1_1_00_1, "pn4_intr"));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 10'b00000_0_0_00_0, "after_intr"));
        tbl.push_back(mk(1, 4'h1, 0, 0, 0, 10'b00011_0_1_00_0, "lw2_stall"));
        tbl.push_back(mk(1, 4'h1, 0, 0, 0, 10'b00000_0_0_01_1, "lw2_replay_req_ignored"));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 10'b00000_0_0_00_0, "lw2_no_second_pause"));
        tbl.push_back(mk(1, 4'h0, 3, 0, 0, 10'b00000_0_0_00_0, "continue"));
        tbl.push_back(mk(1, 4'hF, 3, 0, 0, 10'b00000_0_0_00_0, "unknown_type"));
        tbl.push_back(mk(1, 4'h1, 0, 0, 1, 10'b00000_1_1_00_0, "intr_drops_req"));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 10'b00000_0_0_00_0, "req_dropped"));
        tbl.push_back(mk(1, 4'h2, 1, 0, 0, 10'b00011_0_1_00_0, "pn1_c1"));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 10'b00000_0_0_00_0, "pn1_done"));

        rst                = 1'b1;
        schi_pause_request = 1'b0;
        schi_sched_type    = 4'h0;
        schi_sched_count   = '0;
        schi_mem_pause     = 1'b0;
        schi_interrupt     = 1'b0;
        #2;
        check("reset_state", outs(), 10'b0);
        @(posedge clk);
        #1;
        check("reset_held_over_edge", outs(), 10'b0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            cycle(tbl[i].pr, tbl[i].typ, tbl[i].c, tbl[i].mp, tbl[i].it, got, mexp);
            check(tbl[i].name, got, tbl[i].exp);
        end

        // Asynchronous reset in the middle of a long PAUSE_N (cnt=5 in S_COUNT)
        cycle(1, 4'h2, 6, 0, 0, got, mexp);
        check("pn6_c1", got, mexp);
        schi_pause_request = 1'b0;
        schi_sched_type    = 4'h0;
        schi_sched_count   = '0;
        #1;
        check("pn6_busy_before_rst", outs(), 10'b00011_0_1_00_1);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_immediate", outs(), 10'b0);
        mq.delete();
        @(posedge clk);
        #3;
        check("async_rst_held", outs(), 10'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cycle(1, 4'h2, 1, 0, 0, got, mexp);
        check("post_rst_pn1", got, 10'b00011_0_1_00_0);
        cycle(0, 4'h0, 0, 0, 0, got, mexp);
        check("post_rst_idle", got, 10'b0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 500; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4)       typ = 4'h1;
            else if (r < 8)  typ = 4'h2;
            else if (r == 8) typ = 4'h0;
            else             typ = 4'($urandom_range(0, 15));
            c = ($urandom_range(0, 15) == 0) ? CNT_W'($urandom_range(0, 15))
                                             : CNT_W'($urandom_range(0, 5));
            cycle(($urandom_range(0, 2) == 0), typ, c, ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 19) == 0), got, mexp);
            check("random", got, mexp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
